data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-outstanding data-memory responder for an RV32I load/store unit.
//   A request is accepted in IDLE, optionally held for WAIT_CYCLES wait
//   states, then the access is performed against an internal word array.
//   The registered response is held until the consumer takes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the data array
//   WAIT_CYCLES  wait states between accept and access (0..15)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    request present          req_ready  accepting (IDLE only)
//   req_wr_en    1 = store, 0 = load      req_funct3 RV32I size/sign code
//   req_addr     byte address             req_wdata  right-aligned store data
//   rsp_valid    response present         rsp_ready  consumer takes response
//   rsp_rdata    extended load result (0 for stores and errors)
//   rsp_err      misaligned, illegal size or out-of-range access
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr_en,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DATA_W = 32;
  localparam int AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Latched request
  logic              wr_en_p0;
  logic [2:0]        funct3_p0;
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  // Request fields seen by the access logic
  logic              acc_wr;
  logic [2:0]        acc_f3;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [AW-1:0]     acc_idx;
  logic              acc_in_range;
  logic              acc_err;
  logic [3:0]        acc_be;
  logic [DATA_W-1:0] acc_lanes;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_data;
  logic              do_access;
  logic              do_write;

  // Size/alignment legality, independent of the address range.
  function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic e;
    e = 1'b0;
    if (wr) begin
      case (f3)
        3'b000:  e = 1'b0;
        3'b001:  e = off[0];
        3'b010:  e = (off != 2'b00);
        default: e = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: e = 1'b0;
        3'b001, 3'b101: e = off[0];
        3'b010:         e = (off != 2'b00);
        default:        e = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Select the addressed byte/half from a word and extend it to 32 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] off);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data across every lane so the byte
  // enables alone pick what lands in the array.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [DATA_W-1:0] wd,
                                                    input logic [2:0] f3);
    logic [DATA_W-1:0] l;
    case (f3)
      3'b000:  l = {4{wd[7:0]}};
      3'b001:  l = {2{wd[15:0]}};
      default: l = wd;
    endcase
    return l;
  endfunction

  // With zero wait states the access happens on the accept edge, so the
  // access logic looks straight at the request inputs while in IDLE.
  always_comb begin
    if (state == IDLE) begin
      acc_wr    = req_wr_en;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_wr    = wr_en_p0;
      acc_f3    = funct3_p0;
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
    end
  end

  assign acc_idx      = acc_addr[AW+1:2];
  assign acc_in_range = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
  assign acc_err      = access_err(acc_wr, acc_f3, acc_addr[1:0]) | ~acc_in_range;
  assign acc_be       = store_be(acc_f3, acc_addr[1:0]);
  assign acc_lanes    = store_lanes(acc_wdata, acc_f3);
  assign rd_word      = mem[acc_idx];
  assign load_data    = (acc_err || acc_wr) ? '0
                                            : load_extend(rd_word, acc_f3, acc_addr[1:0]);

  // rst_n gates the access so nothing is written while reset is held.
  assign do_access = rst_n &&
                     (((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0)));
  assign do_write  = do_access && acc_wr && !acc_err;

  // ---- stage p0: request capture on accept ----
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      wr_en_p0  <= req_wr_en;
      funct3_p0 <= req_funct3;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
    end
  end

  // ---- array write on the access edge ----
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_lanes[8*i +: 8];
      end
    end
  end

  // ---- control FSM and registered response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_data;
              rsp_err   <= acc_err;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: two instances (1 and 3 wait states)
// driven with directed scenarios and randomized load/store traffic, checked
// against a byte-addressed reference model of the data array.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic             clk;
  logic [1:0]       rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_wr_en;
  logic [1:0][2:0]  req_funct3;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       rsp_err;

  int n_tests;
  int n_fail;
  int wait_of [2];

  logic [7:0] mem_m   [2][NBYTES];
  bit         known_m [2][NBYTES];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr_en(req_wr_en[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr_en(req_wr_en[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: legality, size and extension computed directly from the
  // RV32I load/store rules on a byte array.
  task automatic model_eval(input int d, input bit wr, input bit [2:0] f3,
                            input bit [31:0] a, output bit err,
                            output bit [31:0] val, output bit known);
    int     nb;
    bit     legal;
    longint v;
    nb    = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    legal = wr ? (f3 < 3) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    err   = !legal || (a % nb != 0) || (a / 4 >= DEPTH);
    val   = 0;
    known = 1;
    if (!err && !wr) begin
      v = 0;
      for (int i = 0; i < nb; i++) begin
        v = v | (longint'(mem_m[d][a+i]) << (8*i));
        known = known && known_m[d][a+i];
      end
      if (f3 < 4 && nb < 4 && ((v >> (8*nb - 1)) & 1) == 1)
        v = v - (longint'(1) << (8*nb));
      val = v[31:0];
    end
  endtask

  task automatic model_store(input int d, input bit [2:0] f3, input bit [31:0] a,
                             input bit [31:0] wd);
    int nb;
    nb = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
    for (int i = 0; i < nb; i++) begin
      mem_m[d][a+i]   = 8'(wd >> (8*i));
      known_m[d][a+i] = 1;
    end
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata[d], 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err[d]), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  // One complete transaction: accept, latency, response, optional hold with
  // rsp_ready low (and stray req_valid), handshake, return to IDLE.
  task automatic txn(input int d, input bit wr, input bit [2:0] f3,
                     input bit [31:0] a, input bit [31:0] wd, input int hold,
                     output bit [31:0] rd, output bit er);
    int        n;
    bit        e_err;
    bit [31:0] e_val;
    bit        e_known;
    model_eval(d, wr, f3, a, e_err, e_val, e_known);
    rd = 0;
    er = 0;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_wr_en[d]  = wr;
    req_funct3[d] = f3;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    @(negedge clk);
    req_valid[d]  = 1'b0;
    req_wr_en[d]  = 1'($urandom);
    req_funct3[d] = 3'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = $urandom;
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      if (req_ready[d] !== 1'b0) chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[d]) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", 32'(n), 32'(wait_of[d] + 1));
    rd = rsp_rdata[d];
    er = rsp_err[d];
    chk("rsp_err", 32'(er), 32'(e_err));
    if (wr || e_err || e_known) chk("rsp_rdata", rd, e_val);
    for (int i = 0; i < hold; i++) begin
      req_valid[d]  = 1'b1;
      req_wr_en[d]  = 1'($urandom);
      req_funct3[d] = 3'($urandom);
      req_addr[d]   = $urandom_range(0, NBYTES - 1);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], rd);
      chk("hold_err",   32'(rsp_err[d]), 32'(er));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("post_req_ready", 32'(req_ready[d]), 32'd1);
    if (wr && !e_err) model_store(d, f3, a, wd);
  endtask

  initial begin
    bit [31:0] rd;
    bit        er;
    bit [31:0] a;
    bit [2:0]  f3;
    bit        wr;
    n_tests    = 0;
    n_fail     = 0;
    wait_of[0] = 1;
    wait_of[1] = 3;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NBYTES; i++) begin
        mem_m[d][i]   = 8'h00;
        known_m[d][i] = 0;
      end
    rst_n      = 2'b00;
    req_valid  = '0;
    req_wr_en  = '0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals(0, "rst0");
    chk_reset_vals(1, "rst1");
    rst_n = 2'b11;

    // Store/load round trip and sub-word behaviour
    txn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    txn(0, 0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw_10", rd, 32'hDEADBEEF);
    txn(0, 1, 3'b000, 32'h11, 32'h000000AA, 0, rd, er);
    txn(0, 0, 3'b000, 32'h11, 32'h0, 0, rd, er);
    chk("lb_11", rd, 32'hFFFFFFAA);
    txn(0, 0, 3'b100, 32'h11, 32'h0, 0, rd, er);
    chk("lbu_11", rd, 32'h000000AA);
    txn(0, 0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    chk("lw_10_merged", rd, 32'hDEADAAEF);
    txn(0, 0, 3'b001, 32'h12, 32'h0, 0, rd, er);
    chk("lh_12", rd, 32'hFFFFDEAD);

    // Error cases
    txn(0, 0, 3'b001, 32'h13, 32'h0, 0, rd, er);
    chk("lh_13_err", 32'(er), 32'd1);
    chk("lh_13_rdata", rd, 32'd0);
    txn(0, 1, 3'b010, 32'h14, 32'h0BADF00D, 0, rd, er);
    txn(0, 1, 3'b010, 32'h16, 32'h11111111, 0, rd, er);
    chk("sw_16_err", 32'(er), 32'd1);
    txn(0, 0, 3'b010, 32'h14, 32'h0, 0, rd, er);
    chk("lw_14_unchanged", rd, 32'h0BADF00D);
    txn(0, 0, 3'b010, 32'(4 * DEPTH), 32'h0, 0, rd, er);
    chk("lw_oor_err", 32'(er), 32'd1);
    txn(0, 0, 3'b011, 32'h10, 32'h0, 0, rd, er);
    chk("ld_f3_011_err", 32'(er), 32'd1);
    txn(0, 1, 3'b011, 32'h10, 32'h0, 0, rd, er);
    chk("sd_f3_011_err", 32'(er), 32'd1);

    // Back-pressure: response held five cycles with a stray request
    txn(0, 0, 3'b010, 32'h10, 32'h0, 5, rd, er);
    chk("lw_hold", rd, 32'hDEADAAEF);

    // Reset during the wait states drops the store
    txn(1, 1, 3'b010, 32'h20, 32'h00000000, 0, rd, er);
    req_valid[1]  = 1'b1;
    req_wr_en[1]  = 1'b1;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 32'h20;
    req_wdata[1]  = 32'h12345678;
    @(negedge clk);
    req_valid[1]  = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk_reset_vals(1, "midrst");
    repeat (3) @(negedge clk);
    rst_n[1] = 1'b1;
    txn(1, 0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    chk("lw_20_not_written", 32'(rd == 32'h12345678), 32'd0);
    chk("lw_20_old", rd, 32'h00000000);
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) chk("no_stray_rsp", 32'(rsp_valid[1]), 32'd0);
    end

    // Randomized traffic on both instances
    for (int k = 0; k < 240; k++) begin
      int d;
      d  = k % 2;
      wr = 1'($urandom);
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (!wr && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3 = f3 | 3'b100;
      a  = 32'($urandom_range(0, DEPTH + 1)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      txn(d, wr, f3, a, $urandom, $urandom_range(0, 2), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
